cpu1_pio_in_debounce: RTL and testbench

Parametrised Avalon-MM input port for the CPU1 system: a WIDTH-bit input with two-flop synchronisation, per-bit debounce, edge capture, and a maskable level interrupt to the Nios II. It replaces single-bit polled inputs such as the software-reset and alarm buttons. Software can poll the clean value or take an interrupt on a chosen edge type.

---
 rtl/cpu1_pio_in_debounce.sv | 108 ++++++++++
 tb/tb_cpu1_pio_in_debounce.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cpu1_pio_in_debounce.sv
// Avalon-MM debounced input port: two-flop sync, per-bit debounce, edge capture
// and a maskable level interrupt.
module cpu1_pio_in_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_next;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    // A disagreement must persist DEBOUNCE_CYCLES clocks; any agreement discards the count.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            deb_next[i] = deb[i];
            cnt_next[i] = '0;
            if (sync2[i] != deb[i]) begin
                if (cnt[i] == CNT_TERM) begin
                    deb_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign toggle = deb ^ deb_next;

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_set = toggle & deb_next;
        end else if (EDGE_TYPE == 1) begin
            edge_set = toggle & ~deb_next;
        end else begin
            edge_set = toggle;
        end
    end

    assign wr_en    = chipselect & ~write_n;
    assign edge_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = deb;
            2'd1:    rd_mux[WIDTH-1:0] = sync2;
            2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            default: rd_mux[WIDTH-1:0] = edge_capture;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1        <= '0;
            sync2        <= '0;
            deb          <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            deb   <= deb_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            if (wr_en && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // Set has priority over a simultaneous write-1-to-clear.
            edge_capture <= (edge_capture & ~edge_clr) | edge_set;
            readdata     <= rd_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_cpu1_pio_in_debounce.sv
// Bench for cpu1_pio_in_debounce: one rising-edge instance and one any-edge
// instance share the bus and inputs.
module tb_cpu1_pio_in_debounce;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata1;
    logic [31:0] readdata2;
    logic        irq1;
    logic        irq2;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    cpu1_pio_in_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata1), .irq(irq1)
    );

    cpu1_pio_in_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata2), .irq(irq2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Expected value is queued when the address is driven, popped once readdata is valid.
    task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp,
                            input bit any_inst);
        @(negedge clk);
        address = a;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check(tag, any_inst ? readdata2 : readdata1, exp_q.pop_front());
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Idle after reset
        for (int a = 0; a < 4; a++) begin
            read_chk("idle_rd", 2'(a), 32'h0, 1'b0);
        end
        check("idle_irq", irq1, 1'b0);

        // Debounce latency: deb updates at E17, readback after E18, irq after E17
        bus_write(2'd2, 32'h1);
        in_port = 4'b0001;
        address = 2'd0;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back((k >= 18) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
            check("lat_data", readdata1, exp_q.pop_front());
            check("lat_irq", irq1, (k >= 17) ? 1'b1 : 1'b0);
        end
        read_chk("lat_cap", 2'd3, 32'h1, 1'b0);
        read_chk("lat_raw", 2'd1, 32'h1, 1'b0);

        // 15-clock pulse is rejected but visible on raw
        @(negedge clk);
        in_port = '0;
        repeat (20) @(negedge clk);
        bus_write(2'd3, 32'hF);
        in_port = 4'b0001;
        address = 2'd1;
        for (int k = 0; k < 21; k++) begin
            if (k == 15) in_port = '0;
            exp_q.push_back((k >= 2 && k <= 16) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
            check("glitch_raw", readdata1, exp_q.pop_front());
            @(negedge clk);
        end
        read_chk("glitch_data", 2'd0, 32'h0, 1'b0);
        read_chk("glitch_cap", 2'd3, 32'h0, 1'b0);
        check("glitch_irq", irq1, 1'b0);

        // Partial write-1-to-clear
        in_port = 4'b0101;
        repeat (20) @(negedge clk);
        read_chk("w1c_pre", 2'd3, 32'h5, 1'b0);
        check("w1c_irq_pre", irq1, 1'b1);
        bus_write(2'd3, 32'h1);
        check("w1c_irq_post", irq1, 1'b0);
        read_chk("w1c_post", 2'd3, 32'h4, 1'b0);
        bus_write(2'd2, 32'h4);
        check("mask_irq", irq1, 1'b1);
        read_chk("mask_rd", 2'd2, 32'h4, 1'b0);

        // Clear on the same edge as a new rising edge: set wins
        in_port = 4'b0100;
        repeat (20) @(negedge clk);
        bus_write(2'd2, 32'h1);
        check("race_irq_pre", irq1, 1'b0);
        in_port = 4'b0101;
        repeat (17) @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd3;
        writedata  = 32'h1;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("race_irq", irq1, 1'b1);
        read_chk("race_cap", 2'd3, 32'h5, 1'b0);

        // Any-edge instance captures both directions; rising-only ignores the fall
        bus_write(2'd3, 32'hF);
        in_port = 4'b0111;
        repeat (20) @(negedge clk);
        read_chk("any_rise", 2'd3, 32'h2, 1'b1);
        bus_write(2'd3, 32'h2);
        read_chk("any_clr", 2'd3, 32'h0, 1'b1);
        in_port = 4'b0101;
        repeat (20) @(negedge clk);
        read_chk("any_fall", 2'd3, 32'h2, 1'b1);
        read_chk("rise_no_fall", 2'd3, 32'h0, 1'b0);

        // Reset mid-count
        bus_write(2'd2, 32'h2);
        check("rst_irq_pre", irq2, 1'b1);
        read_chk("rst_rd_pre", 2'd3, 32'h2, 1'b1);
        @(negedge clk);
        in_port = 4'b1111;
        repeat (8) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_rd1", readdata1, 32'h0);
        check("rst_rd2", readdata2, 32'h0);
        check("rst_irq1", irq1, 1'b0);
        check("rst_irq2", irq2, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (9) @(negedge clk);
        read_chk("rst_restart", 2'd0, 32'h0, 1'b0);
        repeat (10) @(negedge clk);
        read_chk("rst_held_data", 2'd0, 32'hF, 1'b0);
        read_chk("rst_held_cap", 2'd3, 32'hF, 1'b0);
        read_chk("rst_held_cap_any", 2'd3, 32'hF, 1'b1);
        read_chk("rst_mask", 2'd2, 32'h0, 1'b0);
        check("rst_held_irq", irq1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
